// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter for a shared 8-way one-hot select. Grants are registered,
// held while the owner keeps requesting, and revoked after MAX_HOLD cycles.
module rr_decode_arbiter #(
   parameter int MAX_HOLD = 16,
   parameter int CNT_W    = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       Enable,
   input  logic [7:0] Req,
   output logic [7:0] Grant,
   output logic [2:0] GrantIdx,
   output logic       GrantValid,
   output logic       Timeout
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [7:0]       grant_nx;
   logic [2:0]       idx_nx;
   logic             valid_nx;
   logic             timeout_nx;

   logic [2:0]       sel;
   logic [2:0]       probe;
   logic             found;

   // Scan starts one past the last owner; the last owner itself is checked last.
   always_comb begin
      sel   = GrantIdx;
      found = 1'b0;
      probe = GrantIdx;
      for (int i = 1; i <= 8; i++) begin
         probe = GrantIdx + 3'(i);
         if (!found && Req[probe]) begin
            found = 1'b1;
            sel   = probe;
         end
      end
   end

   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      grant_nx   = Grant;
      idx_nx     = GrantIdx;
      valid_nx   = GrantValid;
      timeout_nx = 1'b0;
      case (state)
         IDLE: begin
            grant_nx = 8'h00;
            valid_nx = 1'b0;
            if (Enable && found) begin
               grant_nx = 8'h01 << sel;
               idx_nx   = sel;
               valid_nx = 1'b1;
               cnt_nx   = CNT_W'(1);
               state_nx = BUSY;
            end
         end
         BUSY: begin
            if (!Enable || !Req[GrantIdx]) begin
               grant_nx = 8'h00;
               valid_nx = 1'b0;
               state_nx = IDLE;
            end else if ((MAX_HOLD != 0) && (cnt == CNT_W'(MAX_HOLD))) begin
               grant_nx   = 8'h00;
               valid_nx   = 1'b0;
               timeout_nx = 1'b1;
               state_nx   = IDLE;
            end else if (cnt != {CNT_W{1'b1}}) begin
               cnt_nx = cnt + CNT_W'(1);
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         Grant      <= 8'h00;
         GrantIdx   <= 3'b111;
         GrantValid <= 1'b0;
         Timeout    <= 1'b0;
      end else begin
         state      <= state_nx;
         cnt        <= cnt_nx;
         Grant      <= grant_nx;
         GrantIdx   <= idx_nx;
         GrantValid <= valid_nx;
         Timeout    <= timeout_nx;
      end
   end

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Directed and random stimulus for rr_decode_arbiter, checked against an
// ownership-level reference model.
module tb_rr_decode_arbiter;
   localparam int MH = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       Enable;
   logic [7:0] Req;
   logic [7:0] Grant;
   logic [2:0] GrantIdx;
   logic       GrantValid;
   logic       Timeout;

   int n_vec = 0;
   int n_err = 0;

   // reference model: current owner, last owner, cycles held, revoke pulse
   bit m_valid = 0;
   int m_idx   = 7;
   int m_cnt   = 0;
   bit m_to    = 0;

   rr_decode_arbiter #(.MAX_HOLD(MH), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .Enable(Enable), .Req(Req),
      .Grant(Grant), .GrantIdx(GrantIdx), .GrantValid(GrantValid), .Timeout(Timeout)
   );

   always #5 clk = ~clk;

   task automatic model_edge(input bit rst, input bit en, input logic [7:0] rq);
      if (!rst) begin
         m_valid = 0; m_idx = 7; m_cnt = 0; m_to = 0;
      end else if (!m_valid) begin
         m_to = 0;
         if (en && rq != 8'h00) begin
            for (int k = 1; k <= 8; k++) begin
               if (!m_valid && rq[(m_idx + k) % 8]) begin
                  m_idx   = (m_idx + k) % 8;
                  m_valid = 1;
                  m_cnt   = 1;
               end
            end
         end
      end else begin
         m_to = 0;
         if (!en || !rq[m_idx]) m_valid = 0;
         else if (MH != 0 && m_cnt == MH) begin
            m_valid = 0;
            m_to    = 1;
         end else if (m_cnt < 255) m_cnt++;
      end
   endtask

   task automatic chk(input string tag);
      logic [7:0] eg;
      logic [2:0] ei;
      eg = m_valid ? (8'h01 << m_idx) : 8'h00;
      ei = 3'(m_idx);
      n_vec++;
      assert (Grant === eg) else begin
         n_err++; $error("FAIL %s Grant got %h exp %h", tag, Grant, eg);
      end
      n_vec++;
      assert (GrantIdx === ei) else begin
         n_err++; $error("FAIL %s GrantIdx got %0d exp %0d", tag, GrantIdx, ei);
      end
      n_vec++;
      assert (GrantValid === m_valid) else begin
         n_err++; $error("FAIL %s GrantValid got %b exp %b", tag, GrantValid, m_valid);
      end
      n_vec++;
      assert (Timeout === m_to) else begin
         n_err++; $error("FAIL %s Timeout got %b exp %b", tag, Timeout, m_to);
      end
      n_vec++;
      assert ($onehot0(Grant) === 1'b1) else begin
         n_err++; $error("FAIL %s onehot Grant got %h exp at most one bit", tag, Grant);
      end
   endtask

   task automatic step(input bit rst, input bit en, input logic [7:0] rq, input string tag);
      rst_n = rst; Enable = en; Req = rq;
      @(posedge clk);
      model_edge(rst, en, rq);
      #1 chk(tag);
   endtask

   task automatic expect_grant(input logic [7:0] g, input string tag);
      n_vec++;
      assert (Grant === g) else begin
         n_err++; $error("FAIL %s Grant got %h exp %h", tag, Grant, g);
      end
   endtask

   initial begin
      logic [7:0] r;
      logic [7:0] prev;
      bit         rs, en;
      rst_n = 1'b0; Enable = 1'b0; Req = 8'h00;

      // reset state
      step(0, 0, 8'h00, "reset");
      step(0, 1, 8'hFF, "reset_req");
      expect_grant(8'h00, "reset_const");

      // requester 0 first after reset, then 7 after release
      step(1, 1, 8'h81, "t1_grant0");
      expect_grant(8'h01, "t1_const0");
      step(1, 1, 8'h81, "t1_hold");
      step(1, 1, 8'h80, "t1_release");
      step(1, 1, 8'h80, "t1_grant7");
      expect_grant(8'h80, "t1_const7");
      step(1, 1, 8'h00, "t1_idle");

      // all requesting, each drops after 3 grant cycles
      for (int c = 0; c < 40; c++) begin
         r = 8'hFF;
         if (m_valid && m_cnt == 3) r[m_idx] = 1'b0;
         step(1, 1, r, "t2_rr");
      end
      step(1, 1, 8'h00, "t2_idle");

      // single persistent requester: 4 granted, 1 timeout, regrant
      for (int c = 0; c < 12; c++) step(1, 1, 8'h04, "t3_timeout");
      step(1, 1, 8'h00, "t3_idle");
      step(1, 1, 8'h00, "t3_idle2");

      // two persistent requesters alternate through timeouts
      for (int c = 0; c < 16; c++) step(1, 1, 8'h24, "t4_alt");
      step(1, 1, 8'h00, "t4_idle");
      step(1, 1, 8'h00, "t4_idle2");

      // enable drop mid-ownership, then resume rotation
      step(1, 1, 8'h18, "t5_grant");
      step(1, 0, 8'h18, "t5_en_low");
      expect_grant(8'h00, "t5_const");
      step(1, 1, 8'h18, "t5_resume");
      step(1, 1, 8'h18, "t5_hold");
      step(1, 1, 8'h00, "t5_rel");

      // reset while owned by 6, then priority restarts at 0
      step(1, 1, 8'h40, "t6_grant6");
      step(1, 1, 8'h40, "t6_hold");
      step(0, 1, 8'h40, "t6_reset");
      step(1, 1, 8'h41, "t6_grant0");
      expect_grant(8'h01, "t6_const");
      step(1, 1, 8'h00, "t6_rel");

      // random traffic
      prev = 8'h00;
      for (int c = 0; c < 400; c++) begin
         rs = ($urandom_range(0, 99) != 0);
         en = ($urandom_range(0, 9) != 0);
         r  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : prev;
         if ($urandom_range(0, 1) == 0) r = r & 8'($urandom);
         prev = r;
         step(rs, en, r, "rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/rr_decode_arbiter.md
Name: rr_decode_arbiter

Overview:
- Round-robin arbiter that shares one 8-way one-hot select resource among 8 requesters.
- Produces a registered one-hot Grant vector plus its 3-bit binary index (S-encoding, where bit n of Grant corresponds to index n).
- A grant is held while its owner keeps requesting, up to a programmable hold limit.
- Sits between requesting sub-blocks and the shared one-hot select/enable datapath; it is the sole owner of that select.

Parameters:
- MAX_HOLD, 16, maximum consecutive grant cycles per ownership; 0 = unlimited (no timeout).
- CNT_W, 8, width of the hold counter; MAX_HOLD must be < 2^CNT_W.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- Enable  input  1  arbitration enable; low forces Grant to zero.
- Req  input  8  request vector, bit n = requester n.
- Grant  output  8  registered one-hot grant; all zeros when no owner.
- GrantIdx  output  3  binary index of the current owner; holds the last owner when GrantValid=0.
- GrantValid  output  1  high while Grant is non-zero.
- Timeout  output  1  one-cycle pulse when an ownership is revoked by MAX_HOLD.

Behaviour:
- All outputs are registered.
- Reset, sampled at a clk edge with rst_n=0:
  - Grant=0, GrantIdx=3'b111, GrantValid=0, Timeout=0.
  - State=IDLE, hold counter=0.
  - Priority pointer=7, so requester 0 has first priority after reset.
- Reset overrides everything, including mid-ownership: the grant drops at that edge.
- Invariant: Grant == (GrantValid ? 1<<GrantIdx : 8'h00). Grant is never multi-hot.
- State IDLE:
  - At an edge with Enable=1 and Req!=0, select the first set Req bit scanning GrantIdx+1, GrantIdx+2, ... wrapping modulo 8 (GrantIdx itself is checked last).
  - At that same edge: Grant<=one-hot(sel), GrantIdx<=sel, GrantValid<=1, counter<=1, state<=BUSY.
  - Latency: request sampled at edge k gives Grant visible after edge k.
  - Enable=0 or Req=0: remain IDLE, outputs zero.
- State BUSY (owner = GrantIdx), checked in priority order:
  1. Enable=0: Grant<=0, GrantValid<=0, state<=IDLE, no Timeout.
  2. Req[GrantIdx]=0: release. Grant<=0, GrantValid<=0, state<=IDLE.
  3. MAX_HOLD!=0 and counter==MAX_HOLD: revoke. Grant<=0, GrantValid<=0, Timeout<=1 for exactly one cycle, state<=IDLE.
  4. Otherwise: hold the grant, counter<=counter+1.
     - The counter saturates at 2^CNT_W-1 when MAX_HOLD=0; it must never wrap.
- Owner handover:
  - Every ownership ends with exactly one cycle of Grant=0 before the next grant.
  - The new owner is selected in IDLE using the rotated priority.
  - A revoked requester that is still requesting is therefore served after every other active requester.
- Changes on other Req bits while BUSY have no effect on the current grant.
- A single persistent requester with MAX_HOLD=N gets: N cycles granted, 1 cycle zero (Timeout high), then re-granted.
- Timeout is low in every cycle other than the revoke pulse.
- GrantIdx does not change on release, revoke, or Enable drop.

Test Plan:
- Reset then Req=8'h81 held -> Grant=8'h01, GrantIdx=0 one cycle after the first sampled edge. Drop Req[0] -> Grant=0 for 1 cycle, then Grant=8'h80, GrantIdx=7.
- Req=8'hFF, each owner drops its request after 3 grant cycles -> owners 0,1,...,7,0 in order, separated by exactly one zero-grant cycle, never multi-hot.
- MAX_HOLD=4, Req=8'h04 held constant -> Grant=8'h04 for 4 cycles, then 8'h00 with Timeout=1 for 1 cycle, then 8'h04 again. Pattern repeats.
- MAX_HOLD=4, Req=8'h24 held -> owner 2 for 4 cycles, Timeout, owner 5 for 4 cycles, Timeout, owner 2 again.
- Enable low mid-ownership -> Grant=0 on the next edge, Timeout=0, GrantIdx unchanged. Enable high again with Req set -> rotation continues from the last GrantIdx.
- rst_n low for 1 cycle while BUSY on owner 6 -> all outputs zero and GrantIdx=7 after the edge. Then Req=8'h41 -> Grant=8'h01 (priority reset).
